// File: rtl/spi_shift_crc.sv
// SPI mode-0 byte shifter with selectable SCLK rate and a bit-serial CRC-16 over MOSI or MISO.
// One byte per start pulse; start pulses while busy are dropped.
module spi_shift_crc #(
  parameter logic [15:0] CRC_POLY  = 16'h1021,
  parameter logic [15:0] CRC_INIT  = 16'h0000,
  parameter int unsigned SLOW_HALF = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_write,
  input  logic        start_read,
  input  logic [7:0]  shift_in,
  output logic [7:0]  shift_out,
  input  logic [1:0]  speed,
  input  logic        crc_reset,
  input  logic        crc_source,
  output logic [15:0] crc_out,
  input  logic        miso,
  output logic        mosi,
  output logic        sclk,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t      state, state_nxt;
  logic [7:0]  half;
  logic [7:0]  div;
  logic [7:0]  tx;
  logic [7:0]  rx;
  logic [2:0]  bitcnt;
  logic [15:0] crc;
  logic        phase_end;
  logic        load, sample, shift, done;
  logic        crc_bit;

  function automatic logic [7:0] half_of(input logic [1:0] s);
    case (s)
      2'd0:    return 8'(SLOW_HALF);
      2'd1:    return 8'd8;
      2'd2:    return 8'd2;
      default: return 8'd1;
    endcase
  endfunction

  assign phase_end = (div == half - 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    sample    = 1'b0;
    shift     = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start_write || start_read) begin
        state_nxt = LOW;
        load      = 1'b1;
      end
      LOW: if (phase_end) begin
        state_nxt = HIGH;
        sample    = 1'b1;
      end
      HIGH: if (phase_end) begin
        if (bitcnt == 3'd7) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end else begin
          state_nxt = LOW;
          shift     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The CRC sees the bit on the wire at the sampling edge: outgoing MSB or incoming miso.
  assign crc_bit = crc_source ? miso : tx[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half      <= 8'd1;
      div       <= 8'd0;
      tx        <= 8'hFF;
      rx        <= 8'h00;
      bitcnt    <= 3'd0;
      shift_out <= 8'h00;
      crc       <= CRC_INIT;
    end else begin
      if (load) begin
        tx     <= start_write ? shift_in : 8'hFF;
        half   <= half_of(speed);
        bitcnt <= 3'd0;
        div    <= 8'd0;
      end else if (state != IDLE) begin
        div <= phase_end ? 8'd0 : div + 8'd1;
      end
      if (sample) rx <= {rx[6:0], miso};
      if (shift) begin
        tx     <= {tx[6:0], 1'b1};
        bitcnt <= bitcnt + 3'd1;
      end
      if (done) shift_out <= rx;
      if (crc_reset)
        crc <= CRC_INIT;
      else if (sample)
        crc <= {crc[14:0], 1'b0} ^ ((crc[15] ^ crc_bit) ? CRC_POLY : 16'h0000);
    end
  end

  assign busy    = (state != IDLE);
  assign sclk    = (state == HIGH);
  assign mosi    = busy ? tx[7] : 1'b1;
  assign crc_out = crc;

endmodule

// File: tb/tb_spi_shift_crc.sv
// Randomized bench for spi_shift_crc with a byte-level SPI slave and CRC reference model.
module tb_spi_shift_crc;
  localparam logic [15:0] POLY = 16'h1021;
  localparam logic [15:0] INIT = 16'h0000;
  localparam int          SLOW = 32;

  logic        clk = 1'b0;
  logic        rst, start_write, start_read, crc_reset, crc_source;
  logic [7:0]  shift_in, shift_out;
  logic [1:0]  speed;
  logic [15:0] crc_out;
  logic        miso, mosi, sclk, busy;
  logic        miso_drv, loop_en;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] m_crc;

  assign miso = loop_en ? mosi : miso_drv;
  always #5 clk = ~clk;

  spi_shift_crc #(.CRC_POLY(POLY), .CRC_INIT(INIT), .SLOW_HALF(SLOW)) dut (
    .clk(clk), .rst(rst), .start_write(start_write), .start_read(start_read),
    .shift_in(shift_in), .shift_out(shift_out), .speed(speed),
    .crc_reset(crc_reset), .crc_source(crc_source), .crc_out(crc_out),
    .miso(miso), .mosi(mosi), .sclk(sclk), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b, input int skip_upto);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      if (i > skip_upto) begin
        logic fb;
        fb = r[15] ^ b[7-i];
        r  = {r[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
      end
    return r;
  endfunction

  // Called at a falling edge with the DUT idle; returns at the falling edge where busy drops.
  task automatic xfer(input bit wr, input bit rd, input logic [7:0] din, input logic [1:0] spd,
                      input logic [7:0] slv, input bit lp, input bit src, input bit intf,
                      input int crst_k);
    int h, cyc, rises;
    logic [7:0] mo, txb, rxb;
    bit prev, pulsed;
    h   = (spd == 2'd0) ? SLOW : (spd == 2'd1) ? 8 : (spd == 2'd2) ? 2 : 1;
    txb = wr ? din : 8'hFF;
    rxb = lp ? txb : slv;
    start_write = wr; start_read = rd; shift_in = din; speed = spd;
    crc_source = src; loop_en = lp; miso_drv = slv[7];
    @(negedge clk);
    start_write = 1'b0; start_read = 1'b0;
    speed = ~spd;
    cyc = 0; rises = 0; prev = 1'b0; mo = 8'h00; pulsed = 1'b0;
    while (busy && cyc < 20000) begin
      cyc++;
      if (pulsed) check("crc_rst_edge", crc_out, INIT);
      pulsed = 1'b0;
      if (sclk && !prev) begin
        mo = {mo[6:0], mosi};
        rises++;
        if (rises < 8) miso_drv = slv[7-rises];
      end
      prev = sclk;
      if (intf && cyc == 3) begin
        start_write = 1'b1; start_read = 1'b1; shift_in = ~din;
      end else begin
        start_write = 1'b0; start_read = 1'b0; shift_in = din;
      end
      crc_reset = (crst_k >= 0) && !sclk && (rises == crst_k);
      pulsed = crc_reset;
      @(negedge clk);
    end
    crc_reset = 1'b0;
    check("busy_cycles", cyc, 16 * h);
    check("sclk_rises", rises, 8);
    check("mosi_bits", mo, txb);
    check("shift_out", shift_out, rxb);
    m_crc = (crst_k >= 0) ? crc_byte(INIT, src ? rxb : txb, crst_k)
                          : crc_byte(m_crc, src ? rxb : txb, -1);
    check("crc_out", crc_out, m_crc);
    if (intf) begin
      @(negedge clk);
      check("no_restart", busy, 0);
    end
  endtask

  initial begin
    int rises;
    bit prev, wr, rd;
    rst = 1'b1; start_write = 1'b0; start_read = 1'b0; crc_reset = 1'b0; crc_source = 1'b0;
    shift_in = 8'h00; speed = 2'd0; miso_drv = 1'b1; loop_en = 1'b0;
    m_crc = INIT;
    #12;
    check("rst_busy", busy, 0);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 1);
    check("rst_shift_out", shift_out, 8'h00);
    check("rst_crc", crc_out, INIT);
    @(negedge clk);
    rst = 1'b0;

    xfer(1, 0, 8'hA5, 2'd3, 8'h00, 1, 0, 0, -1);
    xfer(0, 1, 8'h00, 2'd0, 8'h3C, 0, 1, 0, -1);

    crc_reset = 1'b1;
    @(negedge clk);
    crc_reset = 1'b0;
    m_crc = INIT;
    for (int i = 0; i < 512; i++)
      xfer(1, 0, 8'hFF, 2'd3, 8'($urandom), 0, 0, 0, -1);
    check("crc_512ff", crc_out, 16'h7FA1);

    xfer(1, 0, 8'h5A, 2'd2, 8'h96, 0, 0, 1, -1);
    xfer(1, 1, 8'h69, 2'd1, 8'h0F, 0, 1, 0, -1);

    // Abort a write partway through bit 4 with an asynchronous reset.
    start_write = 1'b1; shift_in = 8'hC3; speed = 2'd2;
    @(negedge clk);
    start_write = 1'b0;
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 200 && rises < 4; i++) begin
      if (sclk && !prev) rises++;
      prev = sclk;
      if (rises < 4) @(negedge clk);
    end
    check("abort_reached_bit4", rises, 4);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_sclk", sclk, 0);
    check("abort_mosi", mosi, 1);
    check("abort_shift_out", shift_out, 8'h00);
    check("abort_crc", crc_out, INIT);
    m_crc = INIT;
    @(negedge clk);
    rst = 1'b0;
    xfer(0, 1, 8'h00, 2'd2, 8'hD2, 0, 1, 0, -1);

    xfer(1, 0, 8'hB7, 2'd3, 8'h00, 0, 0, 0, 3);

    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom);
      rd = wr ? 1'($urandom) : 1'b1;
      xfer(wr, rd, 8'($urandom), (($urandom % 8) == 0) ? 2'd0 : 2'($urandom_range(1, 3)),
           8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
